// File: rtl/mig_eval_pkg.sv
// Shared constants, operand encoding and FSM state type for the
// majority-inverter-graph evaluator.
package mig_eval_pkg;

  localparam int MAX_NODES = 16;
  localparam int NUM_X     = 7;
  localparam int NUM_PAT   = 128;
  localparam int SEL_W     = 5;
  localparam int CFG_W     = 18;

  localparam logic [SEL_W-1:0] SEL_CONST0 = 5'd0;
  localparam logic [SEL_W-1:0] SEL_X0     = 5'd1;
  localparam logic [SEL_W-1:0] SEL_NODE0  = 5'd8;

  // cfg_data = {cA, selA, cB, selB, cC, selC}
  localparam int CA_BIT   = 17;
  localparam int SELA_LSB = 12;
  localparam int CB_BIT   = 11;
  localparam int SELB_LSB = 6;
  localparam int CC_BIT   = 5;
  localparam int SELC_LSB = 0;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EVAL = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/mig_eval_seq_maj3.sv
// Shared three-input majority gate with per-operand complement.
module maj3_unit (
  input  logic a,
  input  logic b,
  input  logic c,
  input  logic ca,
  input  logic cb,
  input  logic cc,
  output logic y
);

  logic ax, bx, cx;

  assign ax = a ^ ca;
  assign bx = b ^ cb;
  assign cx = c ^ cc;
  assign y  = (ax & bx) | (ax & cx) | (bx & cx);

endmodule

// File: rtl/mig_eval_seq.sv
// Sequential MIG evaluator: walks a stored program of majority nodes one per
// cycle through a single MAJ3, either for one input vector or all 128.
module mig_eval_seq #(
  parameter int MAX_NODES = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         cfg_we,
  input  logic [3:0]   cfg_addr,
  input  logic [17:0]  cfg_data,
  input  logic [4:0]   num_nodes,
  input  logic         out_inv,
  input  logic         sweep,
  input  logic         start,
  input  logic [6:0]   x,
  output logic         busy,
  output logic         done,
  output logic         result,
  output logic [127:0] tt
);
  import mig_eval_pkg::*;

  localparam logic [4:0] MAXN = 5'(MAX_NODES);

  state_t               state_q, state_d;
  logic [CFG_W-1:0]     prog_q [MAX_NODES];
  logic [MAX_NODES-1:0] node_q;
  logic [3:0]           k_q;
  logic [6:0]           pat_q;
  logic [6:0]           x_q;
  logic [4:0]           n_q;
  logic                 inv_q;
  logic                 sweep_q;
  logic                 result_q;
  logic [127:0]         tt_q;

  logic [CFG_W-1:0]     cur;
  logic [6:0]           x_eff;
  logic [4:0]           n_start;
  logic                 last_node;
  logic                 last_pat;
  logic                 op_a, op_b, op_c;
  logic                 maj_y;

  // Node operands only see nodes already computed in this pattern.
  function automatic logic operand(input logic [4:0]           sel,
                                   input logic [6:0]           xv,
                                   input logic [MAX_NODES-1:0] nodes,
                                   input logic [3:0]           k);
    logic [4:0] j;
    logic       v;
    v = 1'b0;
    j = sel - SEL_NODE0;
    if (sel == SEL_CONST0) begin
      v = 1'b0;
    end else if (sel < SEL_NODE0) begin
      v = xv[3'(sel - SEL_X0)];
    end else if ((sel < SEL_NODE0 + 5'd16) && (j < {1'b0, k})) begin
      v = nodes[j[3:0]];
    end
    return v;
  endfunction

  assign cur       = prog_q[k_q];
  assign x_eff     = sweep_q ? pat_q : x_q;
  assign n_start   = (num_nodes > MAXN) ? MAXN : num_nodes;
  assign last_node = ({1'b0, k_q} == (n_q - 5'd1));
  assign last_pat  = (pat_q == 7'h7f);

  assign op_a = operand(cur[SELA_LSB +: SEL_W], x_eff, node_q, k_q);
  assign op_b = operand(cur[SELB_LSB +: SEL_W], x_eff, node_q, k_q);
  assign op_c = operand(cur[SELC_LSB +: SEL_W], x_eff, node_q, k_q);

  maj3_unit u_maj3 (
    .a  (op_a),
    .b  (op_b),
    .c  (op_c),
    .ca (cur[CA_BIT]),
    .cb (cur[CB_BIT]),
    .cc (cur[CC_BIT]),
    .y  (maj_y)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    busy    = 1'b0;
    done    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) state_d = (n_start == 5'd0) ? ST_DONE : ST_EVAL;
      end
      ST_EVAL: begin
        busy = 1'b1;
        if (last_node && (!sweep_q || last_pat)) state_d = ST_DONE;
      end
      ST_DONE: begin
        done    = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < MAX_NODES; i++) prog_q[i] <= '0;
      node_q   <= '0;
      k_q      <= '0;
      pat_q    <= '0;
      x_q      <= '0;
      n_q      <= '0;
      inv_q    <= 1'b0;
      sweep_q  <= 1'b0;
      result_q <= 1'b0;
      tt_q     <= '0;
    end else begin
      if (cfg_we && (state_q != ST_EVAL)) prog_q[cfg_addr] <= cfg_data;

      case (state_q)
        ST_IDLE: begin
          if (start) begin
            x_q     <= x;
            n_q     <= n_start;
            inv_q   <= out_inv;
            sweep_q <= sweep;
            pat_q   <= '0;
            k_q     <= '0;
            node_q  <= '0;
            // Empty program: the function is just the output polarity.
            if (n_start == 5'd0) begin
              if (sweep) tt_q     <= {128{out_inv}};
              else       result_q <= out_inv;
            end
          end
        end
        ST_EVAL: begin
          node_q[k_q] <= maj_y;
          if (last_node) begin
            k_q    <= '0;
            node_q <= '0;
            if (sweep_q) begin
              tt_q[pat_q] <= maj_y ^ inv_q;
              pat_q       <= pat_q + 7'd1;
            end else begin
              result_q <= maj_y ^ inv_q;
            end
          end else begin
            k_q <= k_q + 4'd1;
          end
        end
        default: ;
      endcase
    end
  end

  assign result = result_q;
  assign tt     = tt_q;

endmodule

// File: tb/tb_mig_eval_seq.sv
// Directed bench for mig_eval_seq: latency, single/sweep results, ignored
// commands during EVAL, forward references, complements and mid-run reset.
module tb_mig_eval_seq;

  logic         clk;
  logic         rst_n;
  logic         cfg_we;
  logic [3:0]   cfg_addr;
  logic [17:0]  cfg_data;
  logic [4:0]   num_nodes;
  logic         out_inv;
  logic         sweep;
  logic         start;
  logic [6:0]   x;
  logic         busy;
  logic         done;
  logic         result;
  logic [127:0] tt;

  localparam logic [127:0] TT5 = 128'hfee8eae8eae8e8c8ece8e8a8e8a8e880;

  int n_cmp = 0;
  int n_bad = 0;

  mig_eval_seq #(.MAX_NODES(16)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cfg_we    (cfg_we),
    .cfg_addr  (cfg_addr),
    .cfg_data  (cfg_data),
    .num_nodes (num_nodes),
    .out_inv   (out_inv),
    .sweep     (sweep),
    .start     (start),
    .x         (x),
    .busy      (busy),
    .done      (done),
    .result    (result),
    .tt        (tt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [17:0] mk(input logic ca, input logic [4:0] sa,
                                     input logic cb, input logic [4:0] sb,
                                     input logic cc, input logic [4:0] sc);
    return {ca, sa, cb, sb, cc, sc};
  endfunction

  task automatic wr(input logic [3:0] a, input logic [17:0] d);
    cfg_we = 1'b1; cfg_addr = a; cfg_data = d;
    @(posedge clk); #1;
    cfg_we = 1'b0;
  endtask

  task automatic prog5();
    wr(4'd0, mk(0, 5'd1, 0, 5'd2, 0, 5'd3));   // MAJ(x0,x1,x2)
    wr(4'd1, mk(0, 5'd1, 0, 5'd3, 0, 5'd7));   // MAJ(x0,x2,x6)
    wr(4'd2, mk(0, 5'd1, 0, 5'd5, 0, 5'd6));   // MAJ(x0,x4,x5)
    wr(4'd3, mk(0, 5'd2, 0, 5'd4, 0, 5'd9));   // MAJ(x1,x3,n1)
    wr(4'd4, mk(0, 5'd8, 0, 5'd10, 0, 5'd11)); // MAJ(n0,n2,n3)
  endtask

  // Pulses start; cyc = number of edges from the start edge up to done (-1 on timeout).
  task automatic run_op(input bit disturb, output int cyc, output logic busy1, output logic done_next);
    logic sv_inv;
    logic [4:0] sv_n;
    sv_inv = out_inv;
    sv_n   = num_nodes;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    cyc   = 1;
    busy1 = busy;
    while (!done && cyc < 3000) begin
      if (disturb && cyc == 2) begin
        start = 1'b1; cfg_we = 1'b1; cfg_addr = 4'd4; cfg_data = '0;
        out_inv = ~sv_inv; num_nodes = 5'd1;
      end
      if (disturb && cyc == 3) begin
        start = 1'b0; cfg_we = 1'b0; out_inv = sv_inv; num_nodes = sv_n;
      end
      @(posedge clk); #1;
      cyc++;
    end
    if (!done) cyc = -1;
    @(posedge clk); #1;
    done_next = done;
  endtask

  initial begin
    int   cyc;
    logic b1, dn;
    logic done_seen;

    rst_n = 1'b0; cfg_we = 1'b0; cfg_addr = '0; cfg_data = '0;
    num_nodes = '0; out_inv = 1'b0; sweep = 1'b0; start = 1'b0; x = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", 128'(busy), 128'd0);
    chk("rst_done", 128'(done), 128'd0);
    chk("rst_result", 128'(result), 128'd0);
    chk("rst_tt", tt, 128'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    prog5();

    num_nodes = 5'd5; out_inv = 1'b0; sweep = 1'b0; x = 7'h07;
    run_op(1'b0, cyc, b1, dn);
    chk("single_x07_cyc", 128'(cyc), 128'd6);
    chk("single_x07_res", 128'(result), 128'd1);
    chk("single_busy", 128'(b1), 128'd1);
    chk("done_one_cycle", 128'(dn), 128'd0);

    x = 7'h03; out_inv = 1'b1;
    run_op(1'b0, cyc, b1, dn);
    chk("inv_x03_res", 128'(result), 128'd1);
    x = 7'h03; out_inv = 1'b0;
    run_op(1'b0, cyc, b1, dn);
    chk("x03_res", 128'(result), 128'd0);

    sweep = 1'b1; out_inv = 1'b0;
    run_op(1'b0, cyc, b1, dn);
    chk("sweep_cyc", 128'(cyc), 128'd641);
    chk("sweep_tt", tt, TT5);
    out_inv = 1'b1;
    run_op(1'b0, cyc, b1, dn);
    chk("sweep_inv_tt", tt, ~TT5);

    sweep = 1'b0; num_nodes = 5'd0; out_inv = 1'b0;
    run_op(1'b0, cyc, b1, dn);
    chk("n0_cyc", 128'(cyc), 128'd1);
    chk("n0_res", 128'(result), 128'd0);
    chk("n0_busy", 128'(b1), 128'd0);
    out_inv = 1'b1;
    run_op(1'b0, cyc, b1, dn);
    chk("n0_inv_res", 128'(result), 128'd1);
    sweep = 1'b1;
    run_op(1'b0, cyc, b1, dn);
    chk("n0_sweep_cyc", 128'(cyc), 128'd1);
    chk("n0_sweep_tt", tt, {128{1'b1}});

    sweep = 1'b0; num_nodes = 5'd5; out_inv = 1'b0; x = 7'h07;
    run_op(1'b1, cyc, b1, dn);
    chk("disturb_cyc", 128'(cyc), 128'd6);
    chk("disturb_res", 128'(result), 128'd1);
    chk("disturb_no_restart", 128'(busy), 128'd0);
    run_op(1'b0, cyc, b1, dn);
    chk("prog_kept_res", 128'(result), 128'd1);

    num_nodes = 5'd31; x = 7'h07;
    run_op(1'b0, cyc, b1, dn);
    chk("clamp_cyc", 128'(cyc), 128'd17);
    chk("clamp_res", 128'(result), 128'd0);

    wr(4'd0, mk(0, 5'd11, 0, 5'd1, 0, 5'd2));
    num_nodes = 5'd1; x = 7'h01;
    run_op(1'b0, cyc, b1, dn);
    chk("fwd_x01_res", 128'(result), 128'd0);
    x = 7'h03;
    run_op(1'b0, cyc, b1, dn);
    chk("fwd_x03_res", 128'(result), 128'd1);

    wr(4'd0, mk(1, 5'd0, 0, 5'd0, 1, 5'd1));   // MAJ(1, 0, ~x0)
    x = 7'h00;
    run_op(1'b0, cyc, b1, dn);
    chk("cmpl_x0_res", 128'(result), 128'd1);
    x = 7'h01;
    run_op(1'b0, cyc, b1, dn);
    chk("cmpl_x1_res", 128'(result), 128'd0);

    prog5();
    num_nodes = 5'd5; sweep = 1'b1; out_inv = 1'b0;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    chk("abort_busy", 128'(busy), 128'd0);
    chk("abort_done", 128'(done), 128'd0);
    chk("abort_tt", tt, 128'd0);
    rst_n = 1'b1;
    done_seen = 1'b0;
    repeat (10) begin
      @(posedge clk); #1;
      if (done) done_seen = 1'b1;
    end
    chk("abort_no_done", 128'(done_seen), 128'd0);
    prog5();
    run_op(1'b0, cyc, b1, dn);
    chk("resweep_cyc", 128'(cyc), 128'd641);
    chk("resweep_tt", tt, TT5);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
